// File: rtl/rv64_pkg.sv
// rv64_pkg: shared definitions for the RV64 execute-stage divide unit.
//   XLEN           operand/result width (64 only)
//   DIV_ITERS      quotient bits produced, one per CALC cycle
//   CNT_W          width of the CALC iteration counter
//   div_op_t       DIV / DIVU / REM / REMU encodings (matches the op port)
//   divrem_state_t IDLE / CALC / FIX / DONE
package rv64_pkg;

  localparam int XLEN      = 64;
  localparam int DIV_ITERS = 64;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } divrem_state_t;

  // True for the ops that treat operands as two's-complement numbers.
  function automatic logic op_is_signed(input div_op_t o);
    return (o == DIV) || (o == REM);
  endfunction

  // True for the ops that return the remainder rather than the quotient.
  function automatic logic op_is_rem(input div_op_t o);
    return (o == REM) || (o == REMU);
  endfunction

endpackage

// File: rtl/divrem64_if.sv
// divrem64_if: request/response bundle between the issue logic and the
// divide unit.
//   in_valid/in_ready   request handshake carrying op, a (dividend), b (divisor)
//   flush               abort whatever is in flight
//   out_valid/out_ready response handshake carrying result
// master = pipeline side, slave = divide unit.
interface divrem64_if;
  import rv64_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/xor64b.sv
// xor64b: conditional bitwise inversion of a 64-bit word.
//   x   in  64  data word
//   inv in  1   invert every bit when high
//   y   out 64  x ^ {64{inv}}
// Adding inv to y afterwards gives a conditional two's-complement negation.
module xor64b (
  input  logic [63:0] x,
  input  logic        inv,
  output logic [63:0] y
);

  assign y = x ^ {64{inv}};

endmodule

// File: rtl/divrem64.sv
// divrem64: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         divrem64_if.slave: request (in_valid/in_ready, op, a, b),
//               flush, response (out_valid/out_ready, result)
// Signed ops divide magnitudes and fix the signs afterwards. Divide-by-zero
// and the signed overflow case bypass the iteration and finish in one cycle.
module divrem64
  import rv64_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  divrem64_if.slave  bus
);

  divrem_state_t   state_r;
  div_op_t         op_r;
  logic            quo_neg_r;
  logic            rem_neg_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic [XLEN-1:0] result_r;

  div_op_t         op_in_s;
  logic            in_signed_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_inv_s;
  logic [XLEN-1:0] b_inv_s;
  logic [XLEN-1:0] a_abs_s;
  logic [XLEN-1:0] b_abs_s;
  logic            b_zero_s;
  logic            ovf_s;
  logic [XLEN-1:0] special_s;

  logic [XLEN:0]   rem_sh_s;
  logic [XLEN:0]   diff_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic [XLEN-1:0] quo_nxt_s;

  logic [XLEN-1:0] fix_src_s;
  logic            fix_neg_s;
  logic [XLEN-1:0] fix_inv_s;
  logic [XLEN-1:0] fix_res_s;

  assign op_in_s     = div_op_t'(bus.op);
  assign in_signed_s = op_is_signed(op_in_s);
  assign a_neg_s     = in_signed_s & bus.a[XLEN-1];
  assign b_neg_s     = in_signed_s & bus.b[XLEN-1];

  // Operand magnitudes: one inverter per operand since both are latched together.
  xor64b u_inv_a (.x(bus.a), .inv(a_neg_s), .y(a_inv_s));
  xor64b u_inv_b (.x(bus.b), .inv(b_neg_s), .y(b_inv_s));

  assign a_abs_s  = a_inv_s + {{(XLEN-1){1'b0}}, a_neg_s};
  assign b_abs_s  = b_inv_s + {{(XLEN-1){1'b0}}, b_neg_s};
  assign b_zero_s = (bus.b == {XLEN{1'b0}});
  assign ovf_s    = in_signed_s
                  & (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                  & (bus.b == {XLEN{1'b1}});

  // Result for the cases that skip iteration (RISC-V defined values).
  always_comb begin
    special_s = {XLEN{1'b0}};
    if (b_zero_s) begin
      special_s = op_is_rem(op_in_s) ? bus.a : {XLEN{1'b1}};
    end else begin
      special_s = op_is_rem(op_in_s) ? {XLEN{1'b0}} : bus.a;
    end
  end

  // One restoring step: shift the dividend MSB into rem, trial-subtract.
  // The shifted remainder needs XLEN+1 bits; if its top bit is set it is
  // certainly >= divisor, otherwise the subtraction borrow decides.
  assign rem_sh_s  = {rem_r, quo_r[XLEN-1]};
  assign diff_s    = rem_sh_s - {1'b0, dvs_r};
  assign ge_s      = rem_sh_s[XLEN] | ~diff_s[XLEN];
  assign rem_nxt_s = ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quo_nxt_s = {quo_r[XLEN-2:0], ge_s};

  // Final sign correction on whichever of quotient/remainder is returned.
  assign fix_src_s = op_is_rem(op_r) ? rem_r : quo_r;
  assign fix_neg_s = op_is_signed(op_r) & (op_is_rem(op_r) ? rem_neg_r : quo_neg_r);

  xor64b u_inv_res (.x(fix_src_s), .inv(fix_neg_s), .y(fix_inv_s));

  assign fix_res_s = fix_inv_s + {{(XLEN-1){1'b0}}, fix_neg_s};

  // Control FSM and datapath registers; flush outranks any new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      op_r      <= DIV;
      quo_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      dvs_r     <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            op_r      <= op_in_s;
            quo_neg_r <= in_signed_s & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            rem_neg_r <= in_signed_s & bus.a[XLEN-1];
            quo_r     <= a_abs_s;
            rem_r     <= {XLEN{1'b0}};
            dvs_r     <= b_abs_s;
            cnt_r     <= CNT_W'(DIV_ITERS - 1);
            if (b_zero_s || ovf_s) begin
              result_r <= special_s;
              state_r  <= DONE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          result_r <= fix_res_s;
          state_r  <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.result    = result_r;

endmodule

// File: tb/tb_divrem64.sv
// tb_divrem64: scoreboard bench for divrem64. Expected results are queued
// when a request is driven and popped when the unit presents a result.
module tb_divrem64;
  import rv64_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  divrem64_if bus ();

  divrem64 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference behaviour of RV64M divide/remainder.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic sgn;
    logic rem;
    sgn = ~op[0];
    rem = op[1];
    if (b == 64'd0) return rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      return rem ? 64'd0 : a;
    if (sgn) begin
      if (rem) return $signed(a) % $signed(b);
      else     return $signed(a) / $signed(b);
    end
    if (rem) return a % b;
    return a / b;
  endfunction

  // Issue one request, wait for the result, check value, latency and handshake.
  // hold > 0 keeps out_ready low for that many cycles after out_valid rises.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold,
                        input string tag);
    int          cyc;
    logic [63:0] held;
    logic        ir_seen;
    exp_q.push_back(exp);
    bus.out_ready = (hold == 0);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    held = bus.result;
    check_val(tag, held, exp_q.pop_front());
    if (hold > 0) begin
      ir_seen = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check_val({tag, "_hold_res"}, bus.result, held);
        check_val({tag, "_hold_ov"}, 64'(bus.out_valid), 64'd1);
        ir_seen = ir_seen | bus.in_ready;
      end
      check_val({tag, "_hold_ir"}, 64'(ir_seen), 64'd0);
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_val({tag, "_post_ir"}, 64'(bus.in_ready), 64'd1);
    check_val({tag, "_post_ov"}, 64'(bus.out_valid), 64'd0);
  endtask

  // Accept an operation and leave it running for 'cycles' CALC cycles.
  task automatic start_and_run(input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input int cycles);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    logic        seen;
    logic [1:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;

    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = 64'd0;
    bus.b         = 64'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ir", 64'(bus.in_ready), 64'd1);
    check_val("rst_ov", 64'(bus.out_valid), 64'd0);
    check_val("rst_res", bus.result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b01, 64'd100, 64'd7, 64'd14, 66, 0, "divu_100_7");
    run_op(2'b11, 64'd100, 64'd7, 64'd2, 66, 0, "remu_100_7");
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, "div_m7_2");
    run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, "rem_m7_2");
    run_op(2'b01, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "divu_by0");
    run_op(2'b11, 64'd5, 64'd0, 64'd5, 1, 0, "remu_by0");
    run_op(2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0, "div_ovf");
    run_op(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, "rem_ovf");
    run_op(2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, "div_7_m2");
    run_op(2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 0, "rem_7_m2");
    run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, "divu_max_1");

    // Backpressure: result held for 10 cycles with out_ready low.
    run_op(2'b01, 64'd1234567, 64'd89, 64'd13871, 66, 10, "bp_divu");

    // Randomised operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      rb  = (i % 2 == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
      run_op(rop, ra, rb, model(rop, ra, rb), 66, 0, "rand");
    end

    // Asynchronous reset in the middle of CALC.
    start_and_run(2'b01, 64'd999, 64'd3, 30);
    rst_n = 1'b0;
    #1;
    check_val("arst_ov", 64'(bus.out_valid), 64'd0);
    check_val("arst_ir", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Flush in the middle of CALC: back to IDLE next edge, no result later.
    start_and_run(2'b01, 64'd999, 64'd3, 30);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_val("flush_ir", 64'(bus.in_ready), 64'd1);
    check_val("flush_ov", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check_val("flush_no_result", 64'(seen), 64'd0);

    // Flush wins over a simultaneous request in IDLE.
    bus.op       = 2'b01;
    bus.a        = 64'd5;
    bus.b        = 64'd0;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check_val("flush_prio_ir", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    check_val("flush_prio_ov", 64'(bus.out_valid), 64'd0);

    run_op(2'b01, 64'd1000, 64'd10, 64'd100, 66, 0, "divu_1000_10");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/divrem64.md
# divrem64

Iterative RV64M integer divide/remainder unit for the execute stage of the RV64F core. It sits beside the ALU and consumes the same register-read operands. It computes DIV, DIVU, REM and REMU on 64-bit operands using a radix-2 restoring algorithm, one quotient bit per cycle. It uses valid/ready handshakes on both sides so the pipeline can stall while an operation is in flight. Sign fix-up (two's-complement negation of operands and results) uses the existing xor64b block for the conditional inversion.

## Interface
- XLEN, 64, operand/result width; only 64 is supported.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  in  64  dividend.
- b  in  64  divisor.
- flush  in  1  abort any in-flight operation; return to IDLE next edge.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  64  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: 64 iterations.
  - FIX: sign correction and result select.
  - DONE: out_valid=1.
- IDLE, on in_valid:
  - Latch op.
  - For signed ops, latch |a| and |b|, and record sign_q = a[63]^b[63] and sign_r = a[63].
  - If b==0 or signed overflow, go directly to DONE; otherwise go to CALC with counter=63.
- CALC, each cycle:
  - Shift {rem, quo} left by 1, bringing in the dividend MSB.
  - If rem ≥ divisor: subtract and set quo[0]=1.
  - When the counter reaches 0, go to FIX.
- FIX: negate quotient if sign_q, negate remainder if sign_r (signed ops only), via (x ^ {64{s}}) + s. Go to DONE.
- DONE: hold result stable until out_valid && out_ready, then go to IDLE.
- Special cases (RISC-V semantics, no exceptions):
  - b==0: quotient = all ones; remainder = a.
  - DIV/REM with a=0x8000_0000_0000_0000, b=all ones: quotient = a; remainder = 0.
- flush: from any state, the next edge returns to IDLE with out_valid=0. The result is discarded. flush has priority over in_valid in the same cycle, so the new operation is not accepted.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, internal registers 0.
- Reset mid-operation: asserting rst_n low at any state forces IDLE immediately (asynchronously). No result is produced.
- out_valid and result must not change while out_valid=1 && out_ready=0.

## Timing
- Accept happens on the edge where in_valid && in_ready.
- Normal latency: out_valid rises 66 edges after the accept edge (64 CALC + FIX + DONE entry).
- Special-case latency: out_valid rises 1 edge after accept.
- No back-to-back overlap. in_ready stays low from the accept edge until the edge after the result handshake completes.
- A new operation is therefore accepted no earlier than the cycle after out_valid && out_ready.
- out_valid depends only on registered state. in_ready depends only on state. There are no combinational in→out paths.

## Structure
- Shared package rv64_pkg holds:
  - XLEN.
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - divrem_state_t enum (IDLE, CALC, FIX, DONE).
  - DIV_ITERS = 64.
- Sub-module: reuse xor64b for conditional inversion. It is instantiated twice, once for operand absolute value and once for result negation, or once if time-multiplexed by state.
- The adder/comparator is plain inline subtraction (65-bit, borrow = compare).

## Test plan
- DIVU a=100, b=7 → result 14, out_valid exactly 66 cycles after accept. Same operands with REMU → 2.
- DIV a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFD (-3). REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF. REMU a=5, b=0 → 5. Both with out_valid 1 cycle after accept.
- DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000. REM with the same operands → 0. Latency 1.
- Backpressure: out_ready held low 10 cycles after out_valid → result stable, in_ready=0 throughout. Raise out_ready → in_ready=1 the next cycle.
- Mid-op aborts:
  - rst_n low 30 cycles into CALC → out_valid=0 and in_ready=1 immediately.
  - flush 30 cycles into CALC → IDLE next edge, no result.
  - Follow-up DIVU 1000/10 → 100.
